// File: rtl/adder_pattern_broadcaster.sv
// adder_pattern_broadcaster: registered operand/carry pattern source for a ripple-adder DFT harness
// Ports:
//   clk   - clock, all state updates on rising edge
//   rst   - asynchronous active-high reset
//   mode  - 00 broadcast, 01 serial load, 10 sweep, 11 hold (sampled in IDLE only)
//   start - level-sampled launch of LOAD or SWEEP from IDLE
//   pin_a - broadcast/serial data for a, also the carry-in source
//   pin_b - broadcast/serial data for b
//   a, b  - N-bit operands to the adder
//   cin   - carry-in to the adder
//   busy  - high while loading or sweeping
//   done  - one-cycle pulse when a load or sweep completes
module adder_pattern_broadcaster #(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [1:0]   mode,
    input  logic         start,
    input  logic         pin_a,
    input  logic         pin_b,
    output logic [N-1:0] a,
    output logic [N-1:0] b,
    output logic         cin,
    output logic         busy,
    output logic         done
);
    localparam int CW = $clog2(N + 1);
    localparam int VW = 2 * N + 1;
    typedef enum logic [1:0] {IDLE, LOAD, SWEEP} state_t;
    state_t state, state_n;
    logic [N-1:0] a_n, b_n, sh_a, sh_a_n, sh_b, sh_b_n, sel;
    logic cin_n, busy_n, done_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [VW-1:0] vec_inc;
    // one-hot mask of the shadow bit written by the current serial sample
    assign sel = N'(1) << cnt;
    // sweep vector is {cin, b, a} with a's LSB as the counter LSB
    assign vec_inc = {cin, b, a} + VW'(1);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            a     <= '0;
            b     <= '0;
            cin   <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            sh_a  <= '0;
            sh_b  <= '0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            a     <= a_n;
            b     <= b_n;
            cin   <= cin_n;
            busy  <= busy_n;
            done  <= done_n;
            sh_a  <= sh_a_n;
            sh_b  <= sh_b_n;
            cnt   <= cnt_n;
        end
    end
    always_comb begin
        state_n = state;
        a_n     = a;
        b_n     = b;
        cin_n   = cin;
        busy_n  = busy;
        done_n  = 1'b0;
        sh_a_n  = sh_a;
        sh_b_n  = sh_b;
        cnt_n   = cnt;
        case (state)
            IDLE: begin
                if (mode == 2'b00) begin
                    a_n   = {N{pin_a}};
                    b_n   = {N{pin_b}};
                    cin_n = pin_a;
                end else if (start && mode == 2'b01) begin
                    state_n = LOAD;
                    busy_n  = 1'b1;
                    cnt_n   = '0;
                end else if (start && mode == 2'b10) begin
                    state_n = SWEEP;
                    busy_n  = 1'b1;
                    {cin_n, b_n, a_n} = '0;
                end
            end
            LOAD: begin
                // the shadows are applied in one edge so the adder never sees a partial pattern
                if (cnt == CW'(N)) begin
                    a_n     = sh_a;
                    b_n     = sh_b;
                    cin_n   = pin_a;
                    done_n  = 1'b1;
                    busy_n  = 1'b0;
                    cnt_n   = '0;
                    state_n = IDLE;
                end else begin
                    sh_a_n = pin_a ? (sh_a | sel) : (sh_a & ~sel);
                    sh_b_n = pin_b ? (sh_b | sel) : (sh_b & ~sel);
                    cnt_n  = cnt + CW'(1);
                end
            end
            SWEEP: begin
                {cin_n, b_n, a_n} = vec_inc;
                if (&vec_inc) begin
                    done_n  = 1'b1;
                    busy_n  = 1'b0;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_adder_pattern_broadcaster.sv
// tb_adder_pattern_broadcaster: directed self-checking bench for adder_pattern_broadcaster
module tb_adder_pattern_broadcaster;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    logic [1:0] mode, m2;
    logic start, pin_a, pin_b, s2, pa2, pb2;
    logic [3:0] a, b;
    logic cin, busy, done;
    logic [1:0] a2, b2;
    logic cin2, busy2, done2;
    int vectors = 0;
    int miscompares = 0;
    adder_pattern_broadcaster #(.N(4)) dut4 (
        .clk(clk), .rst(rst), .mode(mode), .start(start), .pin_a(pin_a), .pin_b(pin_b),
        .a(a), .b(b), .cin(cin), .busy(busy), .done(done)
    );
    adder_pattern_broadcaster #(.N(2)) dut2 (
        .clk(clk), .rst(rst), .mode(m2), .start(s2), .pin_a(pa2), .pin_b(pb2),
        .a(a2), .b(b2), .cin(cin2), .busy(busy2), .done(done2)
    );
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic load4(input logic [3:0] va, input logic [3:0] vb, input logic vc, input bit poke);
        mode  = 2'b01;
        start = 1'b1;
        tick;
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            pin_a = va[k];
            pin_b = vb[k];
            if (poke && k == 1) begin
                start = 1'b1;
                mode  = 2'b10;
            end
            tick;
            start = 1'b0;
        end
        pin_a = vc;
        tick;
    endtask
    initial begin
        mode = 2'b11; start = 1'b0; pin_a = 1'b0; pin_b = 1'b0;
        m2 = 2'b11; s2 = 1'b0; pa2 = 1'b0; pb2 = 1'b0;
        #1;
        check("rst_a", a, 4'h0);
        check("rst_b", b, 4'h0);
        check("rst_cin", cin, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        tick;
        tick;
        rst = 1'b0;
        // broadcast
        mode = 2'b00; pin_a = 1'b1; pin_b = 1'b0;
        tick;
        check("bc1_a", a, 4'hF);
        check("bc1_b", b, 4'h0);
        check("bc1_cin", cin, 1'b1);
        check("bc1_done", done, 1'b0);
        pin_a = 1'b0; pin_b = 1'b1;
        tick;
        check("bc2_a", a, 4'h0);
        check("bc2_b", b, 4'hF);
        check("bc2_cin", cin, 1'b0);
        // serial load, outputs must hold at E1..E4
        mode = 2'b01; start = 1'b1;
        tick;
        start = 1'b0;
        check("ld_e0_busy", busy, 1'b1);
        check("ld_e0_a", a, 4'h0);
        for (int k = 0; k < 4; k++) begin
            pin_a = 4'b1101 >> k;
            pin_b = 4'b0110 >> k;
            tick;
            check("ld_hold_a", a, 4'h0);
            check("ld_hold_b", b, 4'hF);
            check("ld_hold_cin", cin, 1'b0);
            check("ld_hold_done", done, 1'b0);
            check("ld_hold_busy", busy, 1'b1);
        end
        pin_a = 1'b1;
        tick;
        check("ld_a", a, 4'hD);
        check("ld_b", b, 4'h6);
        check("ld_cin", cin, 1'b1);
        check("ld_done", done, 1'b1);
        check("ld_busy", busy, 1'b0);
        tick;
        check("ld_done_pulse", done, 1'b0);
        // reset abort mid-load
        mode = 2'b01; start = 1'b1;
        tick;
        start = 1'b0; pin_a = 1'b1; pin_b = 1'b1;
        tick;
        tick;
        rst = 1'b1;
        #1;
        check("ab_a", a, 4'h0);
        check("ab_b", b, 4'h0);
        check("ab_cin", cin, 1'b0);
        check("ab_busy", busy, 1'b0);
        mode = 2'b11;
        tick;
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick;
            check("ab_no_done", done, 1'b0);
            check("ab_idle_busy", busy, 1'b0);
            check("ab_idle_a", a, 4'h0);
        end
        // start and mode changes inside LOAD are ignored
        load4(4'h6, 4'h3, 1'b0, 1'b1);
        check("ig_a", a, 4'h6);
        check("ig_b", b, 4'h3);
        check("ig_cin", cin, 1'b0);
        check("ig_done", done, 1'b1);
        tick;
        check("ig_no_sweep_busy", busy, 1'b0);
        check("ig_no_sweep_a", a, 4'h6);
        // hold mode
        load4(4'h3, 4'h5, 1'b1, 1'b0);
        check("hd_load_a", a, 4'h3);
        mode = 2'b11; start = 1'b1;
        for (int k = 0; k < 5; k++) begin
            pin_a = k[0]; pin_b = ~k[0];
            tick;
            start = 1'b0;
            check("hd_a", a, 4'h3);
            check("hd_b", b, 4'h5);
            check("hd_cin", cin, 1'b1);
            check("hd_busy", busy, 1'b0);
            check("hd_done", done, 1'b0);
        end
        // exhaustive sweep on the N=2 instance
        m2 = 2'b10; s2 = 1'b1;
        tick;
        s2 = 1'b0;
        check("sw_e0", {cin2, b2, a2}, 5'h00);
        check("sw_e0_busy", busy2, 1'b1);
        repeat (10) tick;
        check("sw_e10", {cin2, b2, a2}, 5'h0A);
        check("sw_e10_done", done2, 1'b0);
        repeat (21) tick;
        check("sw_e31", {cin2, b2, a2}, 5'h1F);
        check("sw_e31_done", done2, 1'b1);
        check("sw_e31_busy", busy2, 1'b0);
        tick;
        check("sw_e32", {cin2, b2, a2}, 5'h1F);
        check("sw_e32_done", done2, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/adder_pattern_broadcaster.md
# adder_pattern_broadcaster

- Parametrised, clocked successor to the combinational pin-to-operand fan-out that drives the ripple-adder DFT harness.
- Takes two package pins and produces registered N-bit operands a and b plus carry-in cin for the adder under test.
- Three modes:
  - broadcast: every bit of a follows pin_a and every bit of b follows pin_b.
  - serial load: arbitrary patterns are shifted in and applied atomically.
  - exhaustive sweep: an on-chip counter walks every {cin,b,a} combination.

## Interface
Parameters:
- N, 16, operand width; legal range 1–32.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- mode  in  2  00 broadcast, 01 serial load, 10 sweep, 11 hold; sampled only in IDLE.
- start  in  1  level sampled each edge; launches LOAD or SWEEP from IDLE.
- pin_a  in  1  broadcast/serial data for a; also source of cin.
- pin_b  in  1  broadcast/serial data for b.
- a  out  N  operand A to adder.
- b  out  N  operand B to adder.
- cin  out  1  carry-in to adder.
- busy  out  1  high while in LOAD or SWEEP.
- done  out  1  one-cycle pulse when a load or sweep completes.

## Operation
- Reset (async, immediate): a=0, b=0, cin=0, busy=0, done=0, shadow registers=0, bit counter=0, state=IDLE.
- States:
  - IDLE → LOAD: mode=01 and start=1.
  - IDLE → SWEEP: mode=10 and start=1.
  - LOAD → IDLE: after N+1 samples.
  - SWEEP → IDLE: when the vector reaches all-ones.
- Behaviour in IDLE, per mode:
  - mode 00: each edge loads a←{N{pin_a}}, b←{N{pin_b}}, cin←pin_a; start is ignored.
  - mode 01/10 without start: outputs hold.
  - mode 11: outputs hold and start is ignored.
- LOAD:
  - Shifts LSB-first into shadow_a and shadow_b; a, b and cin do not change during LOAD, so no partial pattern reaches the adder.
  - Sample k (k=0..N-1) writes shadow_a[k]←pin_a and shadow_b[k]←pin_b.
  - Sample N takes cin from pin_a. On that same edge a←shadow_a, b←shadow_b, cin←pin_a, done=1, busy=0, state=IDLE.
- SWEEP:
  - The start edge sets vector {cin,b,a}←0 and busy=1.
  - Each following edge increments the vector by 1, modulo 2^(2N+1).
  - The edge that produces all-ones also sets done=1 and busy=0, with state returning to IDLE.
  - Afterwards all-ones is held until mode or start changes it.
- In LOAD and SWEEP, start and mode are ignored; only rst aborts.
- done is high for exactly one cycle per completed operation; it is never asserted in broadcast mode.
- Arithmetic: the sweep counter is 2N+1 bits with bit ordering {cin, b[N-1:0], a[N-1:0]}. The a LSB is the counter LSB. The bit counter is ceil(log2(N+1)) bits wide.

## Timing
- Broadcast latency: 1 cycle (pin change at edge E appears on a/b/cin after edge E+1 samples it).
- Serial load, with the start edge as E0:
  - Data bit k is sampled at E(k+1).
  - cin is sampled at E(N+1).
  - a, b, cin and done update at E(N+1).
  - busy is high from after E0 until E(N+1).
- Sweep, with the start edge as E0:
  - Outputs are 0 after E0 and equal v after E(v).
  - The final vector 2^(2N+1)-1 and done both appear after E(2^(2N+1)-1).
- Back-to-back operation: start held high through done relaunches on the edge after done. In IDLE, start is level-sampled.
- Reset mid-operation:
  - All outputs are 0 with no clock required.
  - The first post-reset edge behaves as IDLE.
  - The aborted operation produces no done.

## Test plan
- Reset abort, N=4: start LOAD, assert rst after E2. Required: a=0, b=0, cin=0, busy=0 before the next edge; no done pulse follows.
- Broadcast, N=4, mode 00: pin_a=1, pin_b=0, then toggle. Required: after one edge a=4'hF, b=4'h0, cin=1; after the toggle, one edge later a=4'h0, b=4'hF, cin=0.
- Serial load, N=4:
  - Stimulus: mode 01, start at E0; pin_a bits 1,0,1,1 and pin_b bits 0,1,1,0 at E1–E4; cin bit 1 at E5.
  - Required: a=4'hD, b=4'h6, cin=1 and done=1 only after E5; a, b and cin unchanged at E1–E4.
- Sweep, N=2, mode 10, start at E0:
  - Required: {cin,b,a}=0 after E0, 5'h0A after E10, 5'h1F with done=1 after E31.
  - busy low after E31; value held at E32.
- Ignored controls: during LOAD, pulse start and change mode to 10 at E2. Required: load completes normally at E(N+1) with the shifted pattern, and no sweep begins.
- Hold mode: after a load giving a=4'h3, set mode 11, pulse start, toggle the pins for 5 cycles. Required: a=4'h3, b and cin unchanged, busy=0, done=0 throughout.
